// File: rtl/fir_xifu_host.sv
// CPU-side CV-XIF driver for the FIR XIFU: issues pre-decoded offload requests, commits them,
// serves coprocessor memory requests on an OBI-like port and collects results.
module fir_xifu_host #(
  parameter int unsigned ID_WIDTH        = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,

  // Offload request source
  input  logic                     instr_valid_i,
  output logic                     instr_ready_o,
  input  logic [31:0]              instr_i,
  input  logic [1:0][31:0]         rs_i,
  input  logic                     kill_i,

  // XIF issue
  output logic                     issue_valid_o,
  input  logic                     issue_ready_i,
  output logic [31:0]              issue_instr_o,
  output logic [1:0]               issue_mode_o,
  output logic [ID_WIDTH-1:0]      issue_id_o,
  output logic [1:0][31:0]         issue_rs_o,
  output logic [1:0]               issue_rs_valid_o,
  output logic [31:0]              issue_hartid_o,
  input  logic                     issue_accept_i,

  // XIF compressed
  output logic                     compressed_valid_o,

  // XIF commit
  output logic                     commit_valid_o,
  output logic [ID_WIDTH-1:0]      commit_id_o,
  output logic                     commit_kill_o,

  // XIF memory request
  input  logic                     mem_valid_i,
  output logic                     mem_ready_o,
  input  logic [31:0]              mem_addr_i,
  input  logic                     mem_we_i,
  input  logic [3:0]               mem_be_i,
  input  logic [31:0]              mem_wdata_i,
  input  logic [ID_WIDTH-1:0]      mem_id_i,
  output logic                     mem_resp_exc_o,
  output logic                     mem_resp_dbg_o,

  // XIF memory result
  output logic                     mem_result_valid_o,
  output logic [ID_WIDTH-1:0]      mem_result_id_o,
  output logic [31:0]              mem_result_rdata_o,
  output logic                     mem_result_err_o,

  // XIF result
  input  logic                     result_valid_i,
  output logic                     result_ready_o,
  input  logic [ID_WIDTH-1:0]      result_id_i,
  input  logic [31:0]              result_data_i,
  input  logic [4:0]               result_rd_i,
  input  logic                     result_we_i,

  // Data port
  output logic                     data_req_o,
  output logic                     data_we_o,
  output logic [3:0]               data_be_o,
  output logic [31:0]              data_addr_o,
  output logic [31:0]              data_wdata_o,
  input  logic                     data_gnt_i,
  input  logic                     data_rvalid_i,
  input  logic [31:0]              data_rdata_i,

  // Status
  output logic                     wb_valid_o,
  output logic [4:0]               wb_rd_o,
  output logic [31:0]              wb_data_o,
  output logic                     illegal_o,
  output logic                     id_error_o
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_OUTSTANDING);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MAX_OUTSTANDING - 1);

  typedef enum logic [0:0] {StIdle, StIssue} issue_state_e;
  typedef enum logic [1:0] {MIdle, MReq, MWait, MResp} mem_state_e;

  issue_state_e           state_q;
  logic [31:0]            instr_q;
  logic [1:0][31:0]       rs_q;
  logic                   kill_q;
  logic [ID_WIDTH-1:0]    id_cnt_q;
  logic                   commit_valid_q;
  logic [ID_WIDTH-1:0]    commit_id_q;
  logic                   commit_kill_q;
  logic                   illegal_q;

  logic [CntW-1:0]        outstanding_q;
  logic [ID_WIDTH-1:0]    fifo_q [MAX_OUTSTANDING];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic                   id_error_q;

  logic                   wb_valid_q;
  logic [4:0]             wb_rd_q;
  logic [31:0]            wb_data_q;

  mem_state_e             mstate_q;
  logic [31:0]            maddr_q, mwdata_q, mrdata_q;
  logic                   mwe_q;
  logic [3:0]             mbe_q;
  logic [ID_WIDTH-1:0]    mid_q;

  logic instr_hs, issue_hs, push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  assign instr_ready_o = (state_q == StIdle) && (outstanding_q < MaxCnt);
  assign instr_hs      = instr_valid_i && instr_ready_o;
  assign issue_hs      = (state_q == StIssue) && issue_ready_i;
  assign push          = issue_hs && issue_accept_i;
  // A result with nothing outstanding is flagged but must not underflow the FIFO.
  assign pop           = result_valid_i && (outstanding_q != '0);

  // Issue FSM and commit generation
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      instr_q        <= '0;
      rs_q           <= '0;
      kill_q         <= 1'b0;
      id_cnt_q       <= '0;
      commit_valid_q <= 1'b0;
      commit_id_q    <= '0;
      commit_kill_q  <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      commit_valid_q <= 1'b0;
      illegal_q      <= 1'b0;
      case (state_q)
        StIdle: begin
          if (instr_hs) begin
            instr_q <= instr_i;
            rs_q    <= rs_i;
            kill_q  <= kill_i;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (issue_ready_i) begin
            commit_valid_q <= 1'b1;
            commit_id_q    <= id_cnt_q;
            commit_kill_q  <= kill_q | ~issue_accept_i;
            illegal_q      <= ~issue_accept_i;
            id_cnt_q       <= id_cnt_q + ID_WIDTH'(1);
            state_q        <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // In-order ID tracking
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      id_error_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      outstanding_q <= outstanding_q + CntW'(1);
      else if (!push && pop) outstanding_q <= outstanding_q - CntW'(1);
      if (result_valid_i && ((outstanding_q == '0) || (result_id_i != fifo_q[rd_ptr_q]))) begin
        id_error_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= id_cnt_q;
  end

  // Scalar writeback
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      if (result_valid_i && result_we_i && (result_rd_i != 5'd0)) begin
        wb_valid_q <= 1'b1;
        wb_rd_q    <= result_rd_i;
        wb_data_q  <= result_data_i;
      end
    end
  end

  // Memory FSM: a single transaction in flight
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mstate_q <= MIdle;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mrdata_q <= '0;
      mwe_q    <= 1'b0;
      mbe_q    <= '0;
      mid_q    <= '0;
    end else begin
      case (mstate_q)
        MIdle: begin
          if (mem_valid_i) begin
            maddr_q  <= mem_addr_i;
            mwdata_q <= mem_wdata_i;
            mwe_q    <= mem_we_i;
            mbe_q    <= mem_be_i;
            mid_q    <= mem_id_i;
            mstate_q <= MReq;
          end
        end
        MReq:  if (data_gnt_i) mstate_q <= MWait;
        MWait: begin
          if (data_rvalid_i) begin
            mrdata_q <= data_rdata_i;
            mstate_q <= MResp;
          end
        end
        MResp: mstate_q <= MIdle;
        default: mstate_q <= MIdle;
      endcase
    end
  end

  assign issue_valid_o      = (state_q == StIssue);
  assign issue_instr_o      = instr_q;
  assign issue_rs_o         = rs_q;
  assign issue_rs_valid_o   = 2'b11;
  assign issue_id_o         = id_cnt_q;
  assign issue_mode_o       = 2'b11;
  assign issue_hartid_o     = '0;
  assign compressed_valid_o = 1'b0;

  assign commit_valid_o     = commit_valid_q;
  assign commit_id_o        = commit_id_q;
  assign commit_kill_o      = commit_kill_q;

  assign mem_ready_o        = (mstate_q == MIdle);
  assign mem_resp_exc_o     = 1'b0;
  assign mem_resp_dbg_o     = 1'b0;
  assign mem_result_valid_o = (mstate_q == MResp);
  assign mem_result_id_o    = mid_q;
  assign mem_result_rdata_o = mrdata_q;
  assign mem_result_err_o   = 1'b0;

  assign data_req_o         = (mstate_q == MReq);
  assign data_we_o          = mwe_q;
  assign data_be_o          = mbe_q;
  assign data_addr_o        = maddr_q;
  assign data_wdata_o       = mwdata_q;

  assign result_ready_o     = 1'b1;
  assign wb_valid_o         = wb_valid_q;
  assign wb_rd_o            = wb_rd_q;
  assign wb_data_o          = wb_data_q;
  assign illegal_o          = illegal_q;
  assign id_error_o         = id_error_q;

endmodule

// File: tb/tb_fir_xifu_host.sv
// Scoreboard bench for fir_xifu_host: stimulus pushes expected issue/commit/writeback/memory
// results, a negedge monitor pops and compares them as the DUT produces them.
module tb_fir_xifu_host;
  localparam int unsigned IdW  = 4;
  localparam int unsigned MaxO = 4;

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  logic             instr_valid_i, instr_ready_o, kill_i;
  logic [31:0]      instr_i;
  logic [1:0][31:0] rs_i;
  logic             issue_valid_o, issue_ready_i, issue_accept_i;
  logic [31:0]      issue_instr_o, issue_hartid_o;
  logic [1:0]       issue_mode_o, issue_rs_valid_o;
  logic [IdW-1:0]   issue_id_o;
  logic [1:0][31:0] issue_rs_o;
  logic             compressed_valid_o;
  logic             commit_valid_o, commit_kill_o;
  logic [IdW-1:0]   commit_id_o;
  logic             mem_valid_i, mem_ready_o, mem_we_i, mem_resp_exc_o, mem_resp_dbg_o;
  logic [31:0]      mem_addr_i, mem_wdata_i;
  logic [3:0]       mem_be_i;
  logic [IdW-1:0]   mem_id_i;
  logic             mem_result_valid_o, mem_result_err_o;
  logic [IdW-1:0]   mem_result_id_o;
  logic [31:0]      mem_result_rdata_o;
  logic             result_valid_i, result_ready_o, result_we_i;
  logic [IdW-1:0]   result_id_i;
  logic [31:0]      result_data_i;
  logic [4:0]       result_rd_i;
  logic             data_req_o, data_we_o, data_gnt_i, data_rvalid_i;
  logic [3:0]       data_be_o;
  logic [31:0]      data_addr_o, data_wdata_o, data_rdata_i;
  logic             wb_valid_o, illegal_o, id_error_o;
  logic [4:0]       wb_rd_o;
  logic [31:0]      wb_data_o;

  fir_xifu_host #(.ID_WIDTH(IdW), .MAX_OUTSTANDING(MaxO)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o), .instr_i(instr_i),
    .rs_i(rs_i), .kill_i(kill_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i), .issue_instr_o(issue_instr_o),
    .issue_mode_o(issue_mode_o), .issue_id_o(issue_id_o), .issue_rs_o(issue_rs_o),
    .issue_rs_valid_o(issue_rs_valid_o), .issue_hartid_o(issue_hartid_o),
    .issue_accept_i(issue_accept_i), .compressed_valid_o(compressed_valid_o),
    .commit_valid_o(commit_valid_o), .commit_id_o(commit_id_o), .commit_kill_o(commit_kill_o),
    .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o), .mem_addr_i(mem_addr_i),
    .mem_we_i(mem_we_i), .mem_be_i(mem_be_i), .mem_wdata_i(mem_wdata_i), .mem_id_i(mem_id_i),
    .mem_resp_exc_o(mem_resp_exc_o), .mem_resp_dbg_o(mem_resp_dbg_o),
    .mem_result_valid_o(mem_result_valid_o), .mem_result_id_o(mem_result_id_o),
    .mem_result_rdata_o(mem_result_rdata_o), .mem_result_err_o(mem_result_err_o),
    .result_valid_i(result_valid_i), .result_ready_o(result_ready_o),
    .result_id_i(result_id_i), .result_data_i(result_data_i), .result_rd_i(result_rd_i),
    .result_we_i(result_we_i),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o), .data_gnt_i(data_gnt_i),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .illegal_o(illegal_o), .id_error_o(id_error_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {logic [IdW-1:0] id; logic [31:0] instr; logic [63:0] rs;} iss_t;
  typedef struct packed {logic [IdW-1:0] id; logic kill;} cmt_t;
  typedef struct packed {logic [4:0] rd; logic [31:0] data;} wb_t;
  typedef struct packed {logic [IdW-1:0] id; logic [31:0] rdata; logic is_wr;} mres_t;

  iss_t  exp_iss[$];
  cmt_t  exp_cmt[$];
  wb_t   exp_wb[$];
  mres_t exp_mres[$];
  bit    exp_ill[$];

  logic [IdW-1:0] id_model;
  logic [IdW-1:0] model_ids[$];
  logic           exp_id_err;

  iss_t  m_iss;
  cmt_t  m_cmt;
  wb_t   m_wb;
  mres_t m_mres;

  always @(negedge clk) begin
    if (rst_ni) begin
      if (issue_valid_o) begin
        if (exp_iss.size() == 0) check_eq("issue_unexpected", 1, 0);
        else begin
          m_iss = exp_iss.pop_front();
          check_eq("issue_id", issue_id_o, m_iss.id);
          check_eq("issue_instr", issue_instr_o, m_iss.instr);
          check_eq("issue_rs", issue_rs_o, m_iss.rs);
          check_eq("issue_rs_valid_mode", {issue_rs_valid_o, issue_mode_o}, 4'hF);
        end
      end
      if (commit_valid_o) begin
        if (exp_cmt.size() == 0) check_eq("commit_unexpected", 1, 0);
        else begin
          m_cmt = exp_cmt.pop_front();
          check_eq("commit_id", commit_id_o, m_cmt.id);
          check_eq("commit_kill", commit_kill_o, m_cmt.kill);
        end
      end
      if (illegal_o) begin
        if (exp_ill.size() == 0) check_eq("illegal_unexpected", 1, 0);
        else void'(exp_ill.pop_front());
      end
      if (wb_valid_o) begin
        if (exp_wb.size() == 0) check_eq("wb_unexpected", 1, 0);
        else begin
          m_wb = exp_wb.pop_front();
          check_eq("wb_rd", wb_rd_o, m_wb.rd);
          check_eq("wb_data", wb_data_o, m_wb.data);
        end
      end
      if (mem_result_valid_o) begin
        if (exp_mres.size() == 0) check_eq("mem_result_unexpected", 1, 0);
        else begin
          m_mres = exp_mres.pop_front();
          check_eq("mem_result_id", mem_result_id_o, m_mres.id);
          check_eq("mem_result_err", mem_result_err_o, 0);
          if (!m_mres.is_wr) check_eq("mem_result_rdata", mem_result_rdata_o, m_mres.rdata);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge where the commit should be visible.
  task automatic send(input logic [31:0] instr, input logic kill, input logic acc);
    int n = 0;
    logic [1:0][31:0] rs;
    while (!instr_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready_o) begin
      check_eq("ready_timeout", 0, 1);
      return;
    end
    rs = {instr ^ 32'hA5A5_0000, ~instr};
    instr_valid_i = 1'b1; instr_i = instr; rs_i = rs; kill_i = kill; issue_accept_i = acc;
    exp_iss.push_back(iss_t'{id_model, instr, rs});
    exp_cmt.push_back(cmt_t'{id_model, kill | ~acc});
    if (!acc) exp_ill.push_back(1'b1);
    else model_ids.push_back(id_model);
    id_model++;
    @(negedge clk);
    instr_valid_i = 1'b0; kill_i = 1'b0;
    check_eq("issue_latency", issue_valid_o, 1);
    @(negedge clk);
    check_eq("commit_latency", commit_valid_o, 1);
  endtask

  task automatic result(input logic [IdW-1:0] id, input logic [4:0] rd, input logic we,
                        input logic [31:0] data);
    result_valid_i = 1'b1; result_id_i = id; result_rd_i = rd; result_we_i = we;
    result_data_i = data;
    if (we && rd != 5'd0) exp_wb.push_back(wb_t'{rd, data});
    if (model_ids.size() == 0) exp_id_err = 1'b1;
    else begin
      if (model_ids[0] != id) exp_id_err = 1'b1;
      void'(model_ids.pop_front());
    end
    @(negedge clk);
    result_valid_i = 1'b0;
    check_eq("id_error", id_error_o, exp_id_err);
    check_eq("wb_latency", wb_valid_o, (we && rd != 5'd0));
  endtask

  task automatic mem_access(input logic [31:0] addr, input logic we, input logic [3:0] be,
                            input logic [31:0] wdata, input logic [IdW-1:0] id, input int gnt_dly,
                            input logic [31:0] rdata);
    check_eq("mem_ready_idle", mem_ready_o, 1);
    mem_valid_i = 1'b1; mem_addr_i = addr; mem_we_i = we; mem_be_i = be; mem_wdata_i = wdata;
    mem_id_i = id;
    exp_mres.push_back(mres_t'{id, rdata, we});
    @(negedge clk);
    mem_valid_i = 1'b0;
    check_eq("mem_req_latency", data_req_o, 1);
    check_eq("mem_fields", {data_addr_o, data_we_o, data_be_o}, {addr, we, be});
    if (we) check_eq("mem_wdata", data_wdata_o, wdata);
    for (int i = 0; i < gnt_dly; i++) begin
      @(negedge clk);
      check_eq("mem_req_hold", {data_req_o, data_addr_o}, {1'b1, addr});
      check_eq("mem_ready_busy", mem_ready_o, 0);
    end
    data_gnt_i = 1'b1;
    @(negedge clk);
    data_gnt_i = 1'b0;
    check_eq("mem_req_dropped", data_req_o, 0);
    check_eq("mem_ready_wait", mem_ready_o, 0);
    data_rvalid_i = 1'b1; data_rdata_i = rdata;
    @(negedge clk);
    data_rvalid_i = 1'b0;
    check_eq("mem_result_latency", mem_result_valid_o, 1);
    check_eq("mem_ready_resp", mem_ready_o, 0);
    @(negedge clk);
    check_eq("mem_result_pulse", mem_result_valid_o, 0);
    check_eq("mem_ready_back", mem_ready_o, 1);
  endtask

  initial begin
    rst_ni = 1'b0;
    instr_valid_i = 0; instr_i = '0; rs_i = '0; kill_i = 0;
    issue_ready_i = 1'b1; issue_accept_i = 1'b1;
    mem_valid_i = 0; mem_addr_i = '0; mem_we_i = 0; mem_be_i = '0; mem_wdata_i = '0; mem_id_i = '0;
    result_valid_i = 0; result_id_i = '0; result_data_i = '0; result_rd_i = '0; result_we_i = 0;
    data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = '0;
    id_model = '0; exp_id_err = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst_outputs", {issue_valid_o, commit_valid_o, mem_result_valid_o, data_req_o,
                             wb_valid_o, illegal_o, id_error_o, compressed_valid_o}, 8'h00);
    rst_ni = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", instr_ready_o, 1);

    // Single accepted instruction and its writeback
    send(32'h0000_100B, 1'b0, 1'b1);
    result(4'd0, 5'd5, 1'b1, 32'h0000_CAFE);

    // Rejected issue, then an accepted instruction killed by the core
    send(32'h0000_200B, 1'b0, 1'b0);
    check_eq("reject_ready", instr_ready_o, 1);
    send(32'h0000_300B, 1'b1, 1'b1);
    result(4'd2, 5'd0, 1'b1, 32'h1111_1111);

    // Back-pressure at MAX_OUTSTANDING
    for (int i = 0; i < 4; i++) send(32'h0001_000B + 32'(i), 1'b0, 1'b1);
    @(negedge clk);
    check_eq("ready_full", instr_ready_o, 0);
    result(model_ids[0], 5'd9, 1'b1, 32'hDEAD_0001);
    check_eq("ready_after_pop", instr_ready_o, 1);
    while (model_ids.size() != 0) result(model_ids[0], 5'd10, 1'b1, $urandom);

    // ID wrap 15 -> 0
    for (int i = 0; i < 17; i++) send($urandom, 1'b0, 1'b0);

    // Memory load with delayed grant, then a store
    mem_access(32'h0000_0100, 1'b0, 4'hF, 32'h0, 4'd3, 3, 32'h1234_5678);
    mem_access(32'h0000_0204, 1'b1, 4'h3, 32'hBEEF_0042, 4'd9, 0, 32'h0);

    // Accepted issue and result in the same cycle
    send(32'h0002_000B, 1'b0, 1'b1);
    instr_valid_i = 1'b1; instr_i = 32'h0002_100B; rs_i = {32'h1, 32'h2}; issue_accept_i = 1'b1;
    exp_iss.push_back(iss_t'{id_model, 32'h0002_100B, {32'h1, 32'h2}});
    exp_cmt.push_back(cmt_t'{id_model, 1'b0});
    model_ids.push_back(id_model);
    id_model++;
    @(negedge clk);
    instr_valid_i = 1'b0;
    check_eq("simul_issue_valid", issue_valid_o, 1);
    result(model_ids[0], 5'd7, 1'b1, 32'h7777_0000);
    for (int i = 0; i < 3; i++) send(32'h0003_000B + 32'(i), 1'b0, 1'b1);
    @(negedge clk);
    check_eq("simul_ready_full", instr_ready_o, (model_ids.size() < MaxO));
    while (model_ids.size() != 0) result(model_ids[0], 5'd11, 1'b1, $urandom);

    // Out-of-order result, then a result with nothing outstanding
    send(32'h0004_000B, 1'b0, 1'b1);
    send(32'h0004_100B, 1'b0, 1'b1);
    result(model_ids[1], 5'd12, 1'b1, 32'h0000_0012);
    result(id_model - 4'd2, 5'd13, 1'b1, 32'h0000_0013);
    result(4'd5, 5'd0, 1'b0, 32'h0);
    check_eq("empty_ready", instr_ready_o, 1);

    // Reset mid memory transaction with an instruction outstanding
    send(32'h0005_000B, 1'b0, 1'b1);
    mem_valid_i = 1'b1; mem_addr_i = 32'h0000_0300; mem_we_i = 1'b0; mem_id_i = 4'd5;
    @(negedge clk);
    mem_valid_i = 1'b0;
    check_eq("pre_rst_req", data_req_o, 1);
    rst_ni = 1'b0; data_gnt_i = 1'b1;
    @(negedge clk);
    exp_iss.delete(); exp_cmt.delete(); exp_wb.delete(); exp_mres.delete(); exp_ill.delete();
    model_ids.delete(); id_model = '0; exp_id_err = 1'b0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'hBAD0_BAD0;
    check_eq("midrst_outputs", {issue_valid_o, commit_valid_o, mem_result_valid_o, data_req_o,
                                wb_valid_o, illegal_o, id_error_o}, 7'h00);
    @(negedge clk);
    data_rvalid_i = 1'b0;
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_gnt_i = i[0]; data_rvalid_i = ~i[0];
      @(negedge clk);
      check_eq("postrst_quiet", {mem_result_valid_o, data_req_o, id_error_o, mem_ready_o,
                                 instr_ready_o}, 5'b00011);
    end
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0;

    // Fresh ID numbering after reset
    send(32'h0006_000B, 1'b0, 1'b1);
    result(4'd0, 5'd3, 1'b1, 32'h0600_0600);

    repeat (3) @(negedge clk);
    check_eq("scoreboard_drained",
             exp_iss.size() + exp_cmt.size() + exp_wb.size() + exp_mres.size() + exp_ill.size(),
             0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
